weight_feed_seq: RTL and testbench

WEIGHT_FEED_SEQ -- requirements
Module: weight_feed_seq

---
 rtl/wfs_pkg.sv | 6 +
 rtl/wfs_addr_gen.sv | 32 +++
 rtl/weight_feed_seq.sv | 117 +++++++++++
 tb/tb_weight_feed_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wfs_pkg.sv
// wfs_pkg: shared state encoding and sizing constants for the weight feed sequencer
package wfs_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int RD_LAT_MAX = 4;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, SHIFT, DONE} wfs_state_e;
endpackage

// File: rtl/wfs_addr_gen.sv
// wfs_addr_gen: captured job registers, tile index, tile address and last-tile flag
// Ports: clk, rst (async, active-high); load captures base_addr/num_tiles and clears the
// tile index; advance steps the index; addr = base + index (wraps); last flags the final tile.
module wfs_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_tiles,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] base_q;
  logic [7:0] num_q, idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base_q <= '0;
      num_q <= '0;
      idx <= '0;
    end else if (load) begin
      base_q <= base_addr;
      num_q <= num_tiles;
      idx <= '0;
    end else if (advance) idx <= idx + 8'd1;
  // The address is derived purely from registers that only change when a fetch
  // is about to start, so it naturally holds between reads.
  assign addr = base_q + ADDR_W'(idx);
  assign last = idx == num_q - 8'd1;
endmodule

// File: rtl/weight_feed_seq.sv
// weight_feed_seq: sequences weight-memory reads into byte-serial feed register strobes
// Ports: clk, rst (async, active-high); start/base_addr/num_tiles job request; stall freezes
// shifting; mem_rd_en/mem_addr memory read; wf_en_in parallel load; wf_en_out byte shift;
// out_valid (wf_en_out delayed); busy; done pulse.
// Optional WEIGHT_FEED_SEQ_ABORT_EN adds abort input and aborted pulse output.
module weight_feed_seq
  import wfs_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_tiles,
  input  logic              stall,
`ifdef WEIGHT_FEED_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wf_en_in,
  output logic              wf_en_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);
  localparam int SC_W = $clog2(BYTES_PER_WORD);
  localparam int WC_W = $clog2(RD_LAT_MAX);
  wfs_state_e state, nxt;
  logic [SC_W-1:0] shift_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic cap, adv, last;

  wfs_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk(clk),
    .rst(rst),
    .load(cap),
    .advance(adv),
    .base_addr(base_addr),
    .num_tiles(num_tiles),
    .addr(mem_addr),
    .last(last)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift_cnt <= '0;
      wait_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= nxt;
      shift_cnt <= state == SHIFT ? shift_cnt + SC_W'(wf_en_out) : '0;
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      out_valid <= wf_en_out;
    end

`ifdef WEIGHT_FEED_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) aborted <= 1'b0;
    else aborted <= abort && state != IDLE;
`endif

  assign busy = state != IDLE;

  always_comb begin
    nxt = state;
    mem_rd_en = 1'b0;
    wf_en_in = 1'b0;
    wf_en_out = 1'b0;
    done = 1'b0;
    cap = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE: if (start) begin
        cap = num_tiles != 8'd0;
        nxt = cap ? FETCH : DONE;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        nxt = RD_LAT > 1 ? WAIT : LOAD;
      end
      WAIT: nxt = wait_cnt == WC_W'(RD_LAT - 2) ? LOAD : WAIT;
      LOAD: begin
        wf_en_in = 1'b1;
        nxt = SHIFT;
      end
      SHIFT: begin
        wf_en_out = !stall;
        // The counter wraps back to zero on the final strobe of a word.
        if (wf_en_out && shift_cnt == SC_W'(BYTES_PER_WORD - 1)) begin
          nxt = last ? DONE : FETCH;
          adv = !last;
        end
      end
      DONE: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
`ifdef WEIGHT_FEED_SEQ_ABORT_EN
    if (abort && state != IDLE) begin
      nxt = IDLE;
      mem_rd_en = 1'b0;
      wf_en_in = 1'b0;
      wf_en_out = 1'b0;
      done = 1'b0;
      cap = 1'b0;
      adv = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_weight_feed_seq.sv
// tb_weight_feed_seq: randomized and directed jobs on RD_LAT=1 and RD_LAT=3 instances against a schedule model
module tb_weight_feed_seq;
  localparam int MAXC = 160;
  typedef logic [13:0] vec_t;
  localparam vec_t BUSY = 14'h2000, DN = 14'h1000, RD = 14'h0800, IN = 14'h0400, OUT = 14'h0200, VAL = 14'h0100;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
  logic [7:0] base_addr = '0, num_tiles = '0;
  logic rd_a, in_a, out_a, val_a, busy_a, done_a;
  logic rd_b, in_b, out_b, val_b, busy_b, done_b;
  logic [7:0] addr_a, addr_b;

  weight_feed_seq #(.ADDR_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_tiles(num_tiles), .stall(stall),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .wf_en_in(in_a), .wf_en_out(out_a),
    .out_valid(val_a), .busy(busy_a), .done(done_a)
  );
  weight_feed_seq #(.ADDR_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_tiles(num_tiles), .stall(stall),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .wf_en_in(in_b), .wf_en_out(out_b),
    .out_valid(val_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  vec_t exp_v [2][MAXC];
  logic stall_tab [MAXC];
  logic [7:0] last_addr [2] = '{8'h00, 8'h00};

  task automatic check(string tag, vec_t got, vec_t want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic vec_t obs(int d);
    return d == 0 ? {busy_a, done_a, rd_a, in_a, out_a, val_a, addr_a}
                  : {busy_b, done_b, rd_b, in_b, out_b, val_b, addr_b};
  endfunction

  // Expected per-cycle outputs of a job whose start is driven in cycle 0.
  task automatic build(int d, int lat, logic [7:0] base, int n, output int fin);
    int t, c, cnt;
    logic [7:0] a;
    a = last_addr[d];
    for (int i = 0; i < MAXC; i++) exp_v[d][i] = {6'b0, a};
    if (n == 0) begin
      exp_v[d][1] |= BUSY | DN;
      fin = 2;
      return;
    end
    t = 1;
    for (int k = 0; k < n; k++) begin
      a = base + 8'(k);
      for (int i = t; i < MAXC; i++) exp_v[d][i][7:0] = a;
      exp_v[d][t] |= BUSY | RD;
      for (int w = 1; w < lat; w++) exp_v[d][t + w] |= BUSY;
      exp_v[d][t + lat] |= BUSY | IN;
      c = t + lat + 1;
      cnt = 0;
      while (cnt < 4 && c < MAXC - 2) begin
        exp_v[d][c] |= BUSY;
        if (!stall_tab[c]) begin
          exp_v[d][c] |= OUT;
          exp_v[d][c + 1] |= VAL;
          cnt++;
        end
        c++;
      end
      t = c;
    end
    exp_v[d][t] |= BUSY | DN;
    fin = t + 1;
    last_addr[d] = a;
  endtask

  task automatic fill_stall(bit rnd);
    for (int c = 0; c < MAXC; c++) stall_tab[c] = rnd && c < 90 && $urandom_range(0, 3) == 0;
  endtask

  task automatic run_job(string name, logic [7:0] base, int n, bit extra);
    int f0, f1, lim, lo;
    build(0, 1, base, n, f0);
    build(1, 3, base, n, f1);
    lim = (f0 > f1 ? f0 : f1) + 1;
    lo = (f0 < f1 ? f0 : f1) - 1;
    for (int c = 0; c <= lim; c++) begin
      @(posedge clk);
      #1;
      stall = stall_tab[c];
      if (c == 0) begin
        start = 1'b1;
        base_addr = base;
        num_tiles = 8'(n);
      end else begin
        start = extra && c < lo && $urandom_range(0, 2) == 0;
        base_addr = 8'($urandom);
        num_tiles = 8'($urandom);
      end
      @(negedge clk);
      check($sformatf("%s lat1 c%0d", name, c), obs(0), exp_v[0][c]);
      check($sformatf("%s lat3 c%0d", name, c), obs(1), exp_v[1][c]);
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("reset lat1", obs(0), '0);
    check("reset lat3", obs(1), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    fill_stall(0);
    run_job("single", 8'h10, 1, 0);
    run_job("wrap", 8'hFE, 3, 0);
    fill_stall(0);
    for (int c = 5; c < 8; c++) stall_tab[c] = 1'b1;
    run_job("stall", 8'h40, 1, 0);
    fill_stall(0);
    run_job("zero", 8'h55, 0, 0);
    fill_stall(1);
    run_job("restart", 8'h80, 2, 1);
    fill_stall(0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 8'h20;
    num_tiles = 8'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    #2 rst = 1'b1;
    @(negedge clk);
    check("midjob rst lat1", obs(0), '0);
    check("midjob rst lat3", obs(1), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    last_addr = '{8'h00, 8'h00};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post rst lat1", obs(0), '0);
      check("post rst lat3", obs(1), '0);
    end
    run_job("after rst", 8'hA0, 2, 0);
    for (int j = 0; j < 20; j++) begin
      fill_stall(1);
      run_job($sformatf("rnd%0d", j), 8'($urandom), $urandom_range(0, 4), 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
